// File: rtl/mem_access_unit.sv
// Memory stage of the RV32 pipeline: drives a req/ack data-memory port, formats store data and
// load results, stalls the pipe while an access is outstanding and registers the MEM/WB results.
module mem_access_unit #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_re_M,
    input  logic              mem_we_M,
    input  logic              reg_we_M,
    input  logic [4:0]        rd_M,
    input  logic [31:0]       ALU_out_M,
    input  logic [31:0]       reg2_din_M,
    input  logic [2:0]        mem_read_type_M,
    input  logic [1:0]        mem_store_type_M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_M,
    output logic              reg_we_W,
    output logic [4:0]        rd_W,
    output logic [31:0]       ALU_out_W,
    output logic              misalign_W,
    output logic              bus_err_W
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               reg_we_q, reg_we_d;
    logic [4:0]         rd_q, rd_d;
    logic [31:0]        alu_q, alu_d;
    logic               misalign_q, misalign_d;
    logic               bus_err_q, bus_err_d;

    logic        is_access, misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Access decode and data formatting; EX/MEM inputs stay frozen while stalled.
    always_comb begin
        is_access = mem_we_M | mem_re_M;
        misaligned = 1'b0;
        if (mem_we_M) begin
            unique case (mem_store_type_M)
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = ALU_out_M[0];
                2'b10:   misaligned = |ALU_out_M[1:0];
                default: misaligned = 1'b1;
            endcase
        end else begin
            unique case (mem_read_type_M[1:0])
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = ALU_out_M[0];
                default: misaligned = |ALU_out_M[1:0];
            endcase
        end

        st_be    = 4'b1111;
        st_wdata = reg2_din_M;
        unique case (mem_store_type_M)
            2'b00: begin
                st_be    = 4'b0001 << ALU_out_M[1:0];
                st_wdata = {4{reg2_din_M[7:0]}};
            end
            2'b01: begin
                st_be    = ALU_out_M[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{reg2_din_M[15:0]}};
            end
            default: ;
        endcase

        unique case (ALU_out_M[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = ALU_out_M[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        unique case (mem_read_type_M)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        reg_we_d   = reg_we_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        stall_M    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!is_access) begin
                    reg_we_d = reg_we_M;
                    rd_d     = rd_M;
                    alu_d    = ALU_out_M;
                end else if (misaligned) begin
                    reg_we_d   = 1'b0;
                    misalign_d = 1'b1;
                end else begin
                    stall_M  = 1'b1;
                    state_d  = StReq;
                    req_d    = 1'b1;
                    we_d     = mem_we_M;
                    addr_d   = {ALU_out_M[ADDR_W-1:2], 2'b00};
                    be_d     = mem_we_M ? st_be : 4'b1111;
                    wdata_d  = mem_we_M ? st_wdata : 32'h0;
                    reg_we_d = 1'b0;
                    cnt_d    = 8'h0;
                end
            end
            StReq: begin
                if (dmem_ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    if (we_q) begin
                        reg_we_d = 1'b0;
                    end else begin
                        reg_we_d = reg_we_M;
                        rd_d     = rd_M;
                        alu_d    = ld_data;
                    end
                end else if (cnt_q == CntLast) begin
                    // Abort releases the stall so the faulting instruction leaves the stage.
                    state_d   = StIdle;
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    reg_we_d  = 1'b0;
                end else begin
                    stall_M = 1'b1;
                    cnt_d   = cnt_q + 8'h1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 8'h0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            reg_we_q   <= 1'b0;
            rd_q       <= 5'h0;
            alu_q      <= 32'h0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            reg_we_q   <= reg_we_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign reg_we_W   = reg_we_q;
    assign rd_W       = rd_q;
    assign ALU_out_W  = alu_q;
    assign misalign_W = misalign_q;
    assign bus_err_W  = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected memory requests,
// write-backs and error pulses; a negedge monitor pops and compares them as the DUT emits them.
module tb_mem_access_unit;

    localparam int EvReq = 0;
    localparam int EvWb  = 1;
    localparam int EvMis = 2;
    localparam int EvErr = 3;

    logic        clk, reset;
    logic        mem_re_M, mem_we_M, reg_we_M;
    logic [4:0]  rd_M;
    logic [31:0] ALU_out_M, reg2_din_M;
    logic [2:0]  mem_read_type_M;
    logic [1:0]  mem_store_type_M;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack, stall_M, reg_we_W;
    logic [4:0]  rd_W;
    logic [31:0] ALU_out_W;
    logic        misalign_W, bus_err_W;

    mem_access_unit #(.ADDR_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .mem_re_M(mem_re_M), .mem_we_M(mem_we_M), .reg_we_M(reg_we_M), .rd_M(rd_M),
        .ALU_out_M(ALU_out_M), .reg2_din_M(reg2_din_M),
        .mem_read_type_M(mem_read_type_M), .mem_store_type_M(mem_store_type_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_M(stall_M), .reg_we_W(reg_we_W), .rd_W(rd_W), .ALU_out_W(ALU_out_W),
        .misalign_W(misalign_W), .bus_err_W(bus_err_W)
    );

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        bit          chk_c;
    } ev_t;

    ev_t exp_q[$];
    int  n_total = 0;
    int  n_pass  = 0;
    logic req_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endfunction

    function automatic void push(int kind, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                 bit chk_c);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c; e.chk_c = chk_c;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(int kind, logic [31:0] a, logic [31:0] b, logic [31:0] c);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected: got event kind %0d a=0x%08h c=0x%08h expected none",
                     kind, a, c);
            return;
        end
        e = exp_q.pop_front();
        chk("sb_kind", 32'(kind), 32'(e.kind));
        if (e.kind == EvReq && kind == EvReq) begin
            chk("sb_req_addr", a, e.a);
            chk("sb_req_we_be", b, e.b);
            if (e.chk_c) chk("sb_req_wdata", c, e.c);
        end else if (e.kind == EvWb && kind == EvWb) begin
            chk("sb_wb_rd", a, e.a);
            chk("sb_wb_data", c, e.c);
        end
    endfunction

    always @(negedge clk) begin
        if (dmem_req && !req_prev)
            observe(EvReq, 32'(dmem_addr), {27'h0, dmem_we, dmem_be}, dmem_wdata);
        if (reg_we_W)   observe(EvWb, 32'(rd_W), 32'h0, ALU_out_W);
        if (misalign_W) observe(EvMis, 32'h0, 32'h0, 32'h0);
        if (bus_err_W)  observe(EvErr, 32'h0, 32'h0, 32'h0);
        req_prev = dmem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_re_M = 0; mem_we_M = 0; reg_we_M = 0; rd_M = 0; ALU_out_M = 0; reg2_din_M = 0;
        mem_read_type_M = 0; mem_store_type_M = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Runs one access; ack_delay counts cycles after the first REQ cycle (-1 = never ack).
    task automatic access(input logic we, input logic re, input logic rwe, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] d, input logic [2:0] rt,
                          input logic [1:0] st, input logic [31:0] rdata, input int ack_delay,
                          output int stalls, output int reqs);
        bit last;
        bit done = 0;
        mem_we_M = we; mem_re_M = re; reg_we_M = rwe; rd_M = rd; ALU_out_M = addr;
        reg2_din_M = d; mem_read_type_M = rt; mem_store_type_M = st;
        stalls = 0; reqs = 0;
        for (int k = 0; k < 60; k++) begin
            dmem_ack   = (ack_delay >= 0) && (k == ack_delay + 1);
            dmem_rdata = rdata;
            #1;
            if (stall_M) stalls++;
            if (dmem_req) reqs++;
            last = !stall_M;
            tick();
            if (last) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL access_timeout: got stall still high expected release within 60");
        end
        idle_inputs();
    endtask

    int stalls, reqs;

    initial begin
        idle_inputs();
        reset = 1;
        tick(); tick();
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_reg_we_W", 32'(reg_we_W), 0);
        chk("rst_alu_W", ALU_out_W, 0);
        chk("rst_misalign", 32'(misalign_W), 0);
        chk("rst_bus_err", 32'(bus_err_W), 0);
        reset = 0;
        tick();

        // ALU pass-through
        reg_we_M = 1; rd_M = 5; ALU_out_M = 32'h1234;
        #1 chk("alu_stall", 32'(stall_M), 0);
        push(EvWb, 32'd5, 0, 32'h1234, 0);
        tick();
        idle_inputs();
        tick();

        // LB lane 3, ack 3 cycles after req
        push(EvReq, 32'h10, 32'h0F, 0, 0);
        push(EvWb, 32'd7, 0, 32'hFFFF_FF80, 0);
        access(0, 1, 1, 5'd7, 32'h13, 0, 3'b000, 2'b00, 32'h80FF_0000, 3, stalls, reqs);
        chk("lb_stalls", 32'(stalls), 4);
        chk("lb_reqs", 32'(reqs), 4);

        // SH upper half, immediate ack
        push(EvReq, 32'h20, 32'h1C, 32'hABCD_ABCD, 1);
        access(1, 0, 1, 5'd8, 32'h22, 32'h0000_ABCD, 3'b000, 2'b01, 0, 0, stalls, reqs);
        chk("sh_stalls", 32'(stalls), 1);
        chk("sh_reg_we_W", 32'(reg_we_W), 0);

        // LW misaligned
        push(EvMis, 0, 0, 0, 0);
        access(0, 1, 1, 5'd4, 32'h6, 0, 3'b010, 2'b00, 0, 0, stalls, reqs);
        chk("lw_mis_stalls", 32'(stalls), 0);
        chk("lw_mis_reqs", 32'(reqs), 0);
        chk("lw_mis_pulse", 32'(misalign_W), 1);
        chk("lw_mis_reg_we", 32'(reg_we_W), 0);
        tick();
        chk("lw_mis_pulse_end", 32'(misalign_W), 0);

        // LHU never acked: timeout abort
        push(EvReq, 32'h4, 32'h0F, 0, 0);
        push(EvErr, 0, 0, 0, 0);
        access(0, 1, 1, 5'd3, 32'h4, 0, 3'b101, 2'b00, 0, -1, stalls, reqs);
        chk("to_reqs", 32'(reqs), 15);
        chk("to_stalls", 32'(stalls), 15);
        chk("to_bus_err", 32'(bus_err_W), 1);
        chk("to_req_low", 32'(dmem_req), 0);
        tick();
        chk("to_bus_err_end", 32'(bus_err_W), 0);

        // Reset in the middle of a request
        push(EvReq, 32'h8, 32'h0F, 0, 0);
        mem_re_M = 1; reg_we_M = 1; rd_M = 9; ALU_out_M = 32'h8; mem_read_type_M = 3'b010;
        tick(); tick();
        reset = 1;
        tick();
        chk("mid_rst_req", 32'(dmem_req), 0);
        chk("mid_rst_reg_we", 32'(reg_we_W), 0);
        chk("mid_rst_rd", 32'(rd_W), 0);
        chk("mid_rst_alu", ALU_out_W, 0);
        reset = 0;
        idle_inputs();
        dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_ack = 0;
        chk("stray_ack_reg_we", 32'(reg_we_W), 0);
        chk("stray_ack_req", 32'(dmem_req), 0);
        push(EvReq, 32'hC, 32'h0F, 0, 0);
        push(EvWb, 32'd9, 0, 32'h1234_5678, 0);
        access(0, 1, 1, 5'd9, 32'hC, 0, 3'b010, 2'b00, 32'h1234_5678, 0, stalls, reqs);
        chk("post_rst_stalls", 32'(stalls), 1);

        // More lanes and store types
        push(EvReq, 32'h0, 32'h0F, 0, 0);
        push(EvWb, 32'd10, 0, 32'hFFFF_8001, 0);
        access(0, 1, 1, 5'd10, 32'h2, 0, 3'b001, 2'b00, 32'h8001_0000, 1, stalls, reqs);
        push(EvReq, 32'h0, 32'h0F, 0, 0);
        push(EvWb, 32'd11, 0, 32'h0000_009A, 0);
        access(0, 1, 1, 5'd11, 32'h1, 0, 3'b100, 2'b00, 32'h0000_9A00, 0, stalls, reqs);
        // Load and store both set: the store wins
        push(EvReq, 32'h0, 32'h18, 32'h5A5A_5A5A, 1);
        access(1, 1, 1, 5'd12, 32'h3, 32'h1234_565A, 3'b000, 2'b00, 0, 0, stalls, reqs);
        chk("sb_reg_we_W", 32'(reg_we_W), 0);
        push(EvReq, 32'h40, 32'h1F, 32'hCAFE_F00D, 1);
        access(1, 0, 0, 5'd0, 32'h40, 32'hCAFE_F00D, 3'b000, 2'b10, 0, 2, stalls, reqs);
        chk("sw_stalls", 32'(stalls), 3);
        push(EvMis, 0, 0, 0, 0);
        access(1, 0, 0, 5'd0, 32'h0, 32'h1, 3'b000, 2'b11, 0, 0, stalls, reqs);
        chk("rsv_reqs", 32'(reqs), 0);

        tick(); tick(); tick();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
